uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte on the receiver's single-cycle strobe and stores it in a DEPTH-entry circular FIFO. Bytes are presented to the consumer (command parser, display logic) on a first-word-fall-through valid/ready interface. The block reports fill level and a sticky overflow flag, so bytes lost to a slow consumer are never silently dropped.

Parameters:
DATA_WIDTH, 8, width of each stored byte; must equal the receiver's NUM_DATA_BITS.
DEPTH, 16, number of FIFO entries; power of two, minimum 2.
ADDR_WIDTH, 4, pointer width; must equal log2(DEPTH).

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_reset_n  input  1  synchronous reset, active low; sampled on rising edge of i_clk.
i_rxStrobe  input  1  single-cycle pulse from the UART receiver: i_rxByte is valid this cycle.
i_rxByte  input  DATA_WIDTH  received byte; sampled only when i_rxStrobe=1.
o_data  output  DATA_WIDTH  head-of-FIFO byte; forced to 0 when o_valid=0.
o_valid  output  1  FIFO non-empty; o_data holds the oldest unread byte.
i_ready  input  1  consumer accepts o_data this cycle; ignored when o_valid=0.
o_count  output  ADDR_WIDTH+1  number of stored bytes, 0..DEPTH.
o_full  output  1  o_count==DEPTH.
o_empty  output  1  o_count==0.
o_overflow  output  1  sticky: at least one byte was dropped because the FIFO was full.
i_clearOverflow  input  1  single-cycle request to clear o_overflow.

Behaviour:
- Reset (i_reset_n=0 at a clock edge): write pointer=0, read pointer=0, o_count=0, o_valid=0, o_empty=1, o_full=0, o_overflow=0, o_data=0.
  - Reset is synchronous and overrides every other input that cycle.
  - Reset during a simultaneous strobe drops that byte.
  - Memory contents are not cleared.
- Write event: i_rxStrobe=1 and (o_full=0 or read event in the same cycle).
  - Store i_rxByte at the write pointer; increment the write pointer modulo DEPTH.
- Read event: o_valid=1 and i_ready=1.
  - Increment the read pointer modulo DEPTH.
  - The next entry (if any) appears on o_data in the following cycle.
- Latency:
  - A byte written into an empty FIFO appears on o_data, with o_valid=1, one cycle after the strobe edge.
  - Write-to-read in the same cycle is not possible when the FIFO is empty.
- Count update:
  - Write only: +1.
  - Read only: -1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
  - o_full, o_empty and o_valid are derived from the registered count and match it every cycle.
- Pointer wrap-around: pointers are ADDR_WIDTH bits and wrap from DEPTH-1 to 0 with no gap; data ordering is preserved across the wrap.
- Full with simultaneous read:
  - Strobe while o_full=1 and a read event in the same cycle: the write is accepted and o_count stays at DEPTH.
  - No overflow is flagged.
- Overflow:
  - Strobe while o_full=1 and no read event: the byte is discarded.
  - Pointers, count and memory are unchanged; o_overflow is set to 1 on the next edge.
- Overflow clear:
  - i_clearOverflow=1 clears o_overflow on the next edge.
  - If an overflow event occurs in the same cycle, set wins and o_overflow stays 1.
- Stale inputs:
  - i_ready with o_valid=0 has no effect.
  - i_rxByte is ignored when i_rxStrobe=0.
- Consecutive strobes on back-to-back cycles must each be accepted; the block must not assume UART bit spacing.

Test Plan:
1. Reset, then strobe 0x41, 0x42, 0x43 with i_ready=0 -> o_count=3, o_valid=1, o_data=0x41; raise i_ready for 3 cycles -> o_data 0x41, 0x42, 0x43 in order, then o_empty=1, o_data=0.
2. Write 16 bytes 0x00..0x0F, then strobe 0xAA with i_ready=0 -> o_full=1, o_overflow=1, o_count=16; drain all -> reads 0x00..0x0F, 0xAA never appears.
3. With the FIFO full, strobe 0x55 and assert i_ready in the same cycle -> o_count stays 16, o_overflow stays 0; after 16 more reads the last byte is 0x55.
4. Write/read 40 bytes interleaved so the pointers wrap twice -> output sequence identical to input, o_count never exceeds 16 or underflows.
5. Assert i_clearOverflow in the same cycle as a new overflow -> o_overflow=1; assert it alone next cycle -> o_overflow=0.
6. Load 5 bytes, pull i_reset_n=0 for one cycle while strobing 0x99 -> o_count=0, o_valid=0, o_data=0, o_overflow=0; 0x99 is never output.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind the UART receiver: captures strobed bytes into a
// circular FIFO and presents them first-word-fall-through with level and sticky overflow.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rxStrobe,
  input  logic [DATA_WIDTH-1:0] i_rxByte,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_overflow,
  input  logic                  i_clearOverflow
);

  localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  rd_evt, wr_evt, ovf_evt;

  // A read frees a slot in the same cycle, so a full FIFO still accepts a strobe then.
  always_comb begin
    rd_evt  = (count_q != '0) && i_ready;
    wr_evt  = i_rxStrobe && ((count_q != CNT_DEPTH) || rd_evt);
    ovf_evt = i_rxStrobe && (count_q == CNT_DEPTH) && !rd_evt;

    wr_ptr_d = wr_evt ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_evt ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    case ({wr_evt, rd_evt})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Set beats clear so a drop in the clearing cycle is still reported.
    if (ovf_evt)              overflow_d = 1'b1;
    else if (i_clearOverflow) overflow_d = 1'b0;
    else                      overflow_d = overflow_q;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; a strobe coincident with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && wr_evt) begin
      mem_q[wr_ptr_q] <= i_rxByte;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_empty    = (count_q == '0);
  assign o_full     = (count_q == CNT_DEPTH);
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_data     = o_valid ? mem_q[rd_ptr_q] : '0;

endmodule
